// File: rtl/pc_redirect_unit.sv
// Fetch-side PC register with a valid/ready redirect port.
// A redirect accepted during a stall is buffered and applied when the stall releases.
module pc_redirect_unit #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        redirect_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        addr_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // The window is compared in 33 bits so PC_BASE + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] ADDR_LO = {1'b0, PC_BASE};
    localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(IM_WORDS) << 2);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        addr_err_q, addr_err_d;

    logic        target_legal;
    logic        accept;

    always_comb begin
        target_legal = (redirect_target[1:0] == 2'b00) &&
                       ({1'b0, redirect_target} >= ADDR_LO) &&
                       ({1'b0, redirect_target} <  ADDR_HI);
        accept       = redirect_valid && (state_q == IDLE);

        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        addr_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && target_legal) begin
                    if (stall) begin
                        buf_d   = redirect_target;
                        state_d = PENDING;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else begin
                    // An illegal request still completes the handshake but is dropped.
                    addr_err_d = accept;
                    if (!stall) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            PENDING: begin
                if (!stall) begin
                    pc_d    = buf_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= PC_BASE;
            buf_q      <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_ready   = (state_q == IDLE);
    assign redirect_pending = (state_q == PENDING);
    assign addr_err         = addr_err_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed vector table, randomized run
// against a rule-level model, and a wrap/overflow check on a second instance.
module tb_pc_redirect_unit;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned WORDS = 4096;

    logic        clk;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_ready, redirect_pending, addr_err;
    logic [31:0] pc, pc_plus4;

    logic        w_reset, w_valid;
    logic [31:0] w_target;
    logic        w_ready, w_pending, w_err;
    logic [31:0] w_pc, w_pc_plus4;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(.PC_BASE(BASE), .IM_WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .redirect_ready(redirect_ready), .pc(pc), .pc_plus4(pc_plus4),
        .redirect_pending(redirect_pending), .addr_err(addr_err)
    );

    pc_redirect_unit #(.PC_BASE(32'hFFFF_FFFC), .IM_WORDS(1)) u_wrap (
        .clk(clk), .reset(w_reset), .stall(1'b0),
        .redirect_valid(w_valid), .redirect_target(w_target),
        .redirect_ready(w_ready), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .redirect_pending(w_pending), .addr_err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        vld;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_ready;
        logic        exp_pending;
        logic        exp_err;
    } vec_t;

    vec_t vecs[26];

    // Rule-level reference state for the randomized run
    logic [31:0] m_pc, m_buf;
    bit          m_pending, m_err;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic [31:0] t);
        reset           = r;
        stall           = s;
        redirect_valid  = v;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] e_pc,
                               input logic e_ready, input logic e_pend, input logic e_err);
        cmp({name, ".pc"}, pc, e_pc);
        cmp({name, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
        cmp({name, ".ready"}, {31'd0, redirect_ready}, {31'd0, e_ready});
        cmp({name, ".pending"}, {31'd0, redirect_pending}, {31'd0, e_pend});
        cmp({name, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
    endtask

    function automatic bit is_legal(input logic [31:0] t);
        longint unsigned a, lo, hi;
        a  = longint'(t);
        lo = longint'(BASE);
        hi = lo + 4 * longint'(WORDS);
        return (a % 4 == 0) && (a >= lo) && (a < hi);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic v, input logic [31:0] t);
        if (r) begin
            m_pc      = BASE;
            m_pending = 0;
            m_err     = 0;
            m_buf     = 32'd0;
        end else begin
            m_err = 0;
            if (m_pending) begin
                if (!s) begin
                    m_pc      = m_buf;
                    m_pending = 0;
                end
            end else if (v && is_legal(t)) begin
                if (s) begin
                    m_buf     = t;
                    m_pending = 1;
                end else begin
                    m_pc = t;
                end
            end else begin
                m_err = v;
                if (!s) m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        r, s, v;
        logic [31:0] t;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        w_reset = 1'b1; w_valid = 1'b0; w_target = 32'd0;

        //          rst   stl   vld   target        pc            rdy   pnd   err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3004, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3008, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_3040, 32'h0000_3040, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3044, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_3010, 32'h0000_3010, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_3100, 32'h0000_3010, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_3200, 32'h0000_3010, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_3010, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_3200, 32'h0000_3100, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3104, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0000_3042, 32'h0000_3108, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_310C, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_3110, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3114, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_3118, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_311C, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h0000_3042, 32'h0000_311C, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3120, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 32'h0000_6FFC, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 32'h0000_3100, 32'h0000_3000, 1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_3000, 1'b1, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3004, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].vld, vecs[i].tgt);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ready,
                        vecs[i].exp_pending, vecs[i].exp_err);
        end

        // Randomized run; the first cycle is a reset so the model starts known.
        for (int i = 0; i < 3000; i++) begin
            r = (i == 0) || ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0: t = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
                1: t = (BASE + 32'(4 * $urandom_range(0, WORDS - 1))) | 32'($urandom_range(1, 3));
                2: t = BASE - 32'(4 * $urandom_range(1, 16));
                3: t = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 16));
                default: t = $urandom;
            endcase
            applyStimulus(r, s, v, t);
            model_step(r, s, v, t);
            checkOutput("rand", m_pc, !m_pending, m_pending, m_err);
        end

        // Wrap instance: base at the top of the address space, one legal word.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        w_reset = 1'b0;
        cmp("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
        cmp("wrap.reset_pc_plus4", w_pc_plus4, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        cmp("wrap.pc", w_pc, 32'h0000_0000);
        cmp("wrap.pc_plus4", w_pc_plus4, 32'h0000_0004);
        w_valid = 1'b1; w_target = 32'hFFFF_FFFC;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        cmp("wrap.redirect_top", w_pc, 32'hFFFF_FFFC);
        cmp("wrap.err_legal", {31'd0, w_err}, 32'd0);
        w_target = 32'h0000_0000;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        cmp("wrap.illegal_low_pc", w_pc, 32'h0000_0000);
        cmp("wrap.illegal_low_err", {31'd0, w_err}, 32'd1);
        cmp("wrap.ready", {31'd0, w_ready}, 32'd1);
        cmp("wrap.pending", {31'd0, w_pending}, 32'd0);
        w_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        cmp("wrap.err_clear", {31'd0, w_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
